// File: rtl/gpio_debounce.sv
// gpio_debounce: per-channel button synchroniser, debouncer and press/release/long-press pulse generator
module gpio_debounce #(
  parameter int N        = 2,
  parameter int DB_CYC   = 120000,
  parameter int LONG_CYC = 12000000,
  parameter int CNT_W    = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_i,
  output logic [N-1:0] btn_o,
  output logic [N-1:0] rise_o,
  output logic [N-1:0] fall_o,
  output logic [N-1:0] long_o
);
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_CYC - 1);
  localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] L_SAT  = CNT_W'(LONG_CYC);
  logic [N-1:0]       r_s1, r_s2;
  logic [CNT_W-1:0]   r_dcnt [N];
  logic [CNT_W-1:0]   r_lcnt [N];
  logic [N-1:0]       w_acc;
  // a channel accepts its new level once s2 has disagreed with btn_o for DB_CYC cycles
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < N; i++) w_acc[i] = (r_s2[i] != btn_o[i]) && (r_dcnt[i] == DB_MAX);
  end
  // sync chain, debounce and long-press counters; a release accepted on the long-press cycle wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      btn_o  <= '0;
      rise_o <= '0;
      fall_o <= '0;
      long_o <= '0;
      for (int i = 0; i < N; i++) begin
        r_dcnt[i] <= '0;
        r_lcnt[i] <= '0;
      end
    end else begin
      r_s1 <= btn_i;
      r_s2 <= r_s1;
      for (int i = 0; i < N; i++) begin
        r_dcnt[i] <= (r_s2[i] == btn_o[i] || w_acc[i]) ? '0 : r_dcnt[i] + 1'b1;
        btn_o[i]  <= w_acc[i] ? r_s2[i] : btn_o[i];
        rise_o[i] <= w_acc[i] & r_s2[i];
        fall_o[i] <= w_acc[i] & ~r_s2[i];
        r_lcnt[i] <= !btn_o[i] ? '0 : (r_lcnt[i] == L_SAT ? r_lcnt[i] : r_lcnt[i] + 1'b1);
        long_o[i] <= btn_o[i] && (r_lcnt[i] == L_MAX) && !w_acc[i];
      end
    end
  end
endmodule

// File: tb/tb_gpio_debounce.sv
// tb_gpio_debounce: directed table and sequence checks for gpio_debounce
module tb_gpio_debounce;
  logic       clk = 0;
  logic       rst = 1;
  logic [1:0] btn_i = '0;
  logic [1:0] btn_o, rise_o, fall_o, long_o;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic [1:0] btn;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];

  gpio_debounce #(.N(2), .DB_CYC(4), .LONG_CYC(20), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .btn_i(btn_i), .btn_o(btn_o),
    .rise_o(rise_o), .fall_o(fall_o), .long_o(long_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int n, input logic r, input logic [1:0] b, input logic [7:0] e);
    vec_t v;
    v.rst = r;
    v.btn = b;
    v.exp = e;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic step(input logic r, input logic [1:0] b);
    rst = r;
    btn_i = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {btn_o, rise_o, fall_o, long_o};
  endfunction

  task automatic press(input logic [1:0] m, input int hold);
    int rc[2], fc[2], lc[2], rcy[2], fcy[2], lcy[2];
    int both, ovl;
    bit exp_long;
    both = -1;
    ovl = 0;
    for (int ch = 0; ch < 2; ch++) begin
      rc[ch] = 0; fc[ch] = 0; lc[ch] = 0; rcy[ch] = -1; fcy[ch] = -1; lcy[ch] = -1;
    end
    for (int c = 0; c < hold + 10; c++) begin
      step(0, c < hold ? m : 2'b00);
      if (rise_o == m && both < 0) both = c;
      if ((rise_o & fall_o) != 0) ovl++;
      for (int ch = 0; ch < 2; ch++) begin
        if (rise_o[ch]) begin rc[ch]++; rcy[ch] = c; end
        if (fall_o[ch]) begin fc[ch]++; fcy[ch] = c; end
        if (long_o[ch]) begin lc[ch]++; lcy[ch] = c; end
      end
    end
    exp_long = hold > 20;
    chk($sformatf("press%0d_h%0d_rise_together", m, hold), both, 5);
    chk($sformatf("press%0d_h%0d_rise_fall_overlap", m, hold), ovl, 0);
    for (int ch = 0; ch < 2; ch++) begin
      if (m[ch]) begin
        chk($sformatf("press%0d_h%0d_ch%0d_rise_cnt", m, hold, ch), rc[ch], 1);
        chk($sformatf("press%0d_h%0d_ch%0d_rise_cyc", m, hold, ch), rcy[ch], 5);
        chk($sformatf("press%0d_h%0d_ch%0d_fall_cnt", m, hold, ch), fc[ch], 1);
        chk($sformatf("press%0d_h%0d_ch%0d_fall_cyc", m, hold, ch), fcy[ch], hold + 5);
        chk($sformatf("press%0d_h%0d_ch%0d_long_cnt", m, hold, ch), lc[ch], int'(exp_long));
        if (exp_long) chk($sformatf("press%0d_h%0d_ch%0d_long_cyc", m, hold, ch), lcy[ch], 25);
      end else begin
        chk($sformatf("press%0d_h%0d_ch%0d_idle_pulses", m, hold, ch), rc[ch] + fc[ch] + lc[ch], 0);
      end
    end
    chk($sformatf("press%0d_h%0d_final_btn", m, hold), int'(btn_o), 0);
  endtask

  initial begin
    int first;
    // reset, single press/release on ch0, then a bounce on ch0
    add(3, 1, 2'b00, 8'h00);
    add(5, 0, 2'b01, 8'h00);
    add(1, 0, 2'b01, 8'h50);
    add(1, 0, 2'b01, 8'h40);
    add(5, 0, 2'b00, 8'h40);
    add(1, 0, 2'b00, 8'h04);
    add(1, 0, 2'b00, 8'h00);
    add(3, 0, 2'b01, 8'h00);
    add(2, 0, 2'b00, 8'h00);
    add(5, 0, 2'b01, 8'h00);
    add(1, 0, 2'b01, 8'h50);
    add(5, 0, 2'b00, 8'h40);
    add(1, 0, 2'b00, 8'h04);
    add(2, 0, 2'b00, 8'h00);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].btn);
      chk($sformatf("vec%0d_outs", i), int'(outs()), int'(tbl[i].exp));
    end
    press(2'b10, 30);
    press(2'b10, 15);
    press(2'b01, 20);
    press(2'b01, 21);
    press(2'b11, 8);
    // reset while both buttons are held: outputs clear, then a fresh press is reported
    for (int c = 0; c < 7; c++) step(0, 2'b11);
    chk("held_before_rst", int'(btn_o), 3);
    step(1, 2'b11);
    chk("rst_mid_outs_a", int'(outs()), 0);
    step(1, 2'b11);
    chk("rst_mid_outs_b", int'(outs()), 0);
    first = -1;
    for (int c = 1; c <= 10; c++) begin
      step(0, 2'b11);
      if (rise_o != 0 && first < 0) begin
        first = c;
        chk("post_rst_rise_val", int'(rise_o), 3);
      end
    end
    chk("post_rst_rise_cyc", first, 6);
    chk("post_rst_btn", int'(btn_o), 3);
    for (int c = 0; c < 10; c++) step(0, 2'b00);
    chk("end_idle_btn", int'(btn_o), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
